// File: rtl/opb_reg_pkg.sv
// rtl/opb_reg_pkg.sv - shared types and OPB/user byte-lane helpers for OPB register slaves
package opb_reg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } ack_state_e;

    localparam int OPB_DW  = 32;
    localparam int OPB_BEW = 4;

    // OPB bit 0 is the MSB, so OPB bit i lands on user bit (DW-1-i).
    function automatic logic [OPB_DW-1:0] opb_to_user(input logic [0:OPB_DW-1] d);
        logic [OPB_DW-1:0] u;
        u = '0;
        for (int i = 0; i < OPB_DW; i++) begin
            u[OPB_DW-1-i] = d[i];
        end
        return u;
    endfunction

    function automatic logic [0:OPB_DW-1] user_to_opb(input logic [OPB_DW-1:0] u);
        logic [0:OPB_DW-1] d;
        d = '0;
        for (int i = 0; i < OPB_DW; i++) begin
            d[i] = u[OPB_DW-1-i];
        end
        return d;
    endfunction

    // BE[i] covers OPB byte i, which is user byte (BEW-1-i).
    function automatic logic [OPB_DW-1:0] be_to_mask(input logic [0:OPB_BEW-1] be);
        logic [OPB_DW-1:0] m;
        m = '0;
        for (int i = 0; i < OPB_BEW; i++) begin
            if (be[i]) begin
                m[OPB_DW-1-8*i -: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// rtl/opb_slave_ack_fsm.sv - address decode and single-cycle IDLE/ACK handshake for OPB register slaves
module opb_slave_ack_fsm
    import opb_reg_pkg::*;
#(
    parameter int                  C_AWIDTH   = 32,
    parameter logic [C_AWIDTH-1:0] C_BASEADDR = 32'h01000400,
    parameter logic [C_AWIDTH-1:0] C_HIGHADDR = 32'h010004FF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [0:C_AWIDTH-1] abus,
    input  logic                select,
    input  logic                rnw,
    output logic                accept,
    output logic                rnw_q,
    output logic                xfer_ack
);

    ack_state_e state;
    ack_state_e state_next;
    logic       hit;

    assign hit = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A hit during ACK is deliberately dropped so acks are never back-to-back.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    accept     = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnw_q <= 1'b0;
        end else if (accept) begin
            rnw_q <= rnw;
        end
    end

    assign xfer_ack = (state == ACK);

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// rtl/opb_register_ppc2simulink.sv - OPB-writable 32-bit control register for fabric logic; optional readback via PPC2SIMULINK_READBACK_EN
module opb_register_ppc2simulink
    import opb_reg_pkg::*;
#(
    parameter int                      C_OPB_AWIDTH  = 32,
    parameter int                      C_OPB_DWIDTH  = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR    = 32'h01000400,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR    = 32'h010004FF,
    parameter logic [OPB_DW-1:0]       C_RESET_VALUE = 32'h00000000
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:OPB_BEW-1]      OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic [OPB_DW-1:0]       user_data_out,
    output logic                    user_data_valid
);

    logic              accept;
    logic              rnw_q;
    logic              xfer_ack;
    logic              be_any_q;
    logic [OPB_DW-1:0] reg_q;
    logic [OPB_DW-1:0] wr_mask;
    logic              unused_seq_addr;

    opb_slave_ack_fsm #(
        .C_AWIDTH   (C_OPB_AWIDTH),
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_ack_fsm (
        .clk      (OPB_Clk),
        .rst      (OPB_Rst),
        .abus     (OPB_ABus),
        .select   (OPB_select),
        .rnw      (OPB_RNW),
        .accept   (accept),
        .rnw_q    (rnw_q),
        .xfer_ack (xfer_ack)
    );

    assign wr_mask = be_to_mask(OPB_BE);

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            reg_q    <= C_RESET_VALUE;
            be_any_q <= 1'b0;
        end else if (accept) begin
            be_any_q <= |OPB_BE;
            if (!OPB_RNW) begin
                reg_q <= (reg_q & ~wr_mask) | (opb_to_user(OPB_DBus) & wr_mask);
            end
        end
    end

    // Strobe rides on the ack cycle, so a reset mid-transfer kills it with the ack.
    assign user_data_valid = xfer_ack & ~rnw_q & be_any_q;
    assign user_data_out   = reg_q;

`ifdef PPC2SIMULINK_READBACK_EN
    assign Sl_DBus = (xfer_ack && rnw_q) ? user_to_opb(reg_q) : '0;
`else
    assign Sl_DBus = '0;
`endif

    assign Sl_xferAck      = xfer_ack;
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;
    assign unused_seq_addr = OPB_seqAddr;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// tb/tb_opb_register_ppc2simulink.sv - scoreboard bench for opb_register_ppc2simulink
module tb_opb_register_ppc2simulink;

    localparam logic [31:0] BASE    = 32'h01000400;
    localparam logic [31:0] HIGH    = 32'h010004FF;
    localparam logic [31:0] RST_VAL = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw;
    logic        sel;
    logic        seq;
    logic [0:31] sl_dbus;
    logic        xfer_ack;
    logic        err_ack;
    logic        retry;
    logic        tout_sup;
    logic [31:0] udata;
    logic        uvalid;

    opb_register_ppc2simulink #(
        .C_RESET_VALUE (RST_VAL)
    ) dut (
        .OPB_Clk         (clk),
        .OPB_Rst         (rst),
        .OPB_ABus        (abus),
        .OPB_BE          (be),
        .OPB_DBus        (dbus),
        .OPB_RNW         (rnw),
        .OPB_select      (sel),
        .OPB_seqAddr     (seq),
        .Sl_DBus         (sl_dbus),
        .Sl_xferAck      (xfer_ack),
        .Sl_errAck       (err_ack),
        .Sl_retry        (retry),
        .Sl_toutSup      (tout_sup),
        .user_data_out   (udata),
        .user_data_valid (uvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          ack_cyc;
        logic [31:0] data;
        logic        valid;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model;
    bit          ack_now;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a <= HIGH);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (xfer_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: ack at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                    chk("user_data_out", udata, e.data);
                    chk("user_data_valid", 32'(uvalid), 32'(e.valid));
                    chk("read_data", sl_dbus, e.rdata);
                end
            end else begin
                chk("idle_valid", 32'(uvalid), 32'd0);
                chk("idle_dbus", sl_dbus, 32'd0);
            end
        end
    end

    // One bus cycle; the model decides acceptance from the spec rules.
    task automatic drive_cycle(input logic [31:0] a, input logic [31:0] d,
                               input logic [0:3] b, input logic r, input logic s);
        exp_t e;
        @(posedge clk);
        #1;
        sel  = s;
        abus = s ? a : 32'd0;
        dbus = s ? d : 32'd0;
        be   = s ? b : 4'd0;
        rnw  = s ? r : 1'b0;
        if (s && in_window(a) && !ack_now) begin
            if (!r) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) model[31-8*i -: 8] = d[31-8*i -: 8];
                end
            end
            e.ack_cyc = cyc + 1;
            e.data    = model;
            e.valid   = !r && (b != 4'b0000);
`ifdef PPC2SIMULINK_READBACK_EN
            e.rdata   = r ? model : 32'd0;
`else
            e.rdata   = 32'd0;
`endif
            sb.push_back(e);
            ack_now = 1'b1;
        end else begin
            ack_now = 1'b0;
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [0:3] b,
                        input logic r, input int hold);
        for (int i = 0; i < hold; i++) drive_cycle(a, d, b, r, 1'b1);
        drive_cycle(32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1; sel = 1'b0; abus = '0; dbus = '0; be = '0; rnw = 1'b0; seq = 1'b0;
        model = RST_VAL; ack_now = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_data", udata, RST_VAL);
        chk("reset_ack", 32'(xfer_ack), 32'd0);
        chk("reset_valid", 32'(uvalid), 32'd0);
        chk("reset_dbus", sl_dbus, 32'd0);
        chk("tied_outputs", {29'd0, err_ack, retry, tout_sup}, 32'd0);

        xfer(BASE, 32'h12345678, 4'b1111, 1'b0, 1);
        xfer(32'h010004FC, 32'hAABBCCDD, 4'b0100, 1'b0, 1);
        @(negedge clk);
        chk("alias_byte_write", udata, 32'h12BB5678);
        xfer(BASE, 32'hFFFFFFFF, 4'b0000, 1'b0, 1);
        @(negedge clk);
        chk("be_zero_hold", udata, 32'h12BB5678);
        xfer(BASE, 32'd0, 4'b1111, 1'b1, 1);
        xfer(BASE, 32'h55AA33CC, 4'b1111, 1'b0, 4);
        xfer(32'h01000500, 32'h0BADF00D, 4'b1111, 1'b0, 1);
        xfer(32'h010003FC, 32'h0BADF00D, 4'b1111, 1'b0, 1);
        @(negedge clk);
        chk("miss_no_write", udata, 32'h55AA33CC);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0, 1: a = BASE + ($urandom_range(0, 255) & 32'hFC);
                2:    a = ($urandom_range(0, 1) != 0) ? HIGH + 1 + $urandom_range(0, 64)
                                                      : BASE - 1 - $urandom_range(0, 64);
                default: a = $urandom;
            endcase
            xfer(a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) drive_cycle(32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        end

        drive_cycle(BASE, 32'hCAFEF00D, 4'b1111, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("ack_before_reset", 32'(xfer_ack), 32'd1);
        rst = 1'b1;
        #1;
        chk("ack_dropped_on_reset", 32'(xfer_ack), 32'd0);
        chk("reset_reverts_data", udata, RST_VAL);
        chk("reset_dbus_zero", sl_dbus, 32'd0);
        chk("reset_valid_zero", 32'(uvalid), 32'd0);
        sb.delete();
        sel = 1'b0; abus = '0; dbus = '0; be = '0; rnw = 1'b0;
        model = RST_VAL; ack_now = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        xfer(BASE + 32'h40, 32'h01020304, 4'b1001, 1'b0, 1);
        xfer(BASE, 32'd0, 4'b1111, 1'b1, 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("final_value", udata, model);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
